fft_frame_packetizer: RTL and testbench
=======================================

Name: fft_frame_packetizer

Overview:
- Avalon-ST source that feeds the sink port of the team's FFT core.
- Collects a free-running real sample stream into FFT_LEN-point frames using a ping-pong double buffer.
- Emits each frame as one packet with SOP/EOP framing, the fft_pts/inverse control fields, and full ready backpressure.
- Sits between the ADC/sample front end and the FFT sink.

Parameters:
- DW, 10, sample width; signed two's-complement real part (imag also DW).
- FFT_LEN, 128, points per frame; power of 2, 8..1024.
- PTS_W, 8, width of the fft_pts field; must hold FFT_LEN.

Ports:
- clk_clk  in  1  single clock.
- reset_reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample strobe; no backpressure.
- in_data  in  DW  signed real sample.
- inverse  in  1  FFT direction; sampled at the first write of each frame.
- src_valid  out  1  Avalon-ST valid.
- src_ready  in  1  Avalon-ST ready; readyLatency = 0.
- src_error  out  2  constant 2'b00.
- src_sop  out  1  start of packet.
- src_eop  out  1  end of packet.
- src_data  out  1+PTS_W+2*DW (29 at defaults)  {inverse, fft_pts, imag, real}.
- overrun  out  1  sticky sample-drop flag.
- clr_overrun  in  1  clears overrun.

Behaviour:
Reset (synchronous, active-high):
- src_valid, src_sop, src_eop, src_data, overrun = 0.
- Both banks empty; write bank = 0; write index = 0.
- Reset mid-packet abandons the packet: src_valid = 0 the cycle after reset is sampled, and partial frames are discarded.

Write side:
- in_valid writes in_data to wr_bank[wr_idx]; wr_idx increments.
- Write at wr_idx = FFT_LEN-1: mark bank full, record the latched inverse bit for that bank, toggle wr_bank, set wr_idx = 0.
- Target bank still full (not yet drained): the sample is dropped, overrun sets, and wr_idx stays 0. Filling restarts at index 0 on the first in_valid after that bank frees.

Read FSM:
- IDLE -> PREFETCH when any bank is full (oldest first). PREFETCH covers the registered RAM read.
- SEND: src_valid = 1. A beat transfers when src_valid && src_ready.
- Beat k of a frame: src_sop = (k==0), src_eop = (k==FFT_LEN-1).
- Beat payload: real = sample k, imag = 0, fft_pts = FFT_LEN, inverse = bank's latched bit.
- After the EOP transfer the bank is marked empty. Go to PREFETCH if the other bank is full, else IDLE.

Timing and handshake:
- Latency: src_valid rises exactly 2 cycles after the clock edge that writes the last sample of a frame, provided the FSM is IDLE.
- While src_valid && !src_ready, src_data, src_sop and src_eop hold stable.
- src_valid never drops mid-packet.
- With src_ready held high, a frame is FFT_LEN contiguous beats.
- Back-to-back full banks: the second packet's SOP beat follows the first packet's EOP beat after exactly 1 bubble cycle (PREFETCH).

Simultaneous events:
- Writing a bank's last sample while the other bank's EOP transfers is legal. The freed bank is writable on the next cycle.
- in_valid in the same cycle a bank frees: the sample is dropped, because the free takes effect next cycle.
- clr_overrun and a new drop in the same cycle: overrun = 1 (set wins).

Optional Feature:
- Macro FFT_PKT_OVR_CNT_EN.
- Defined: adds output ovr_count[15:0]. It increments once per dropped sample, saturates at 16'hFFFF, clears on reset and on clr_overrun; a same-cycle drop loads 1.
- Undefined: the port and counter are absent; overrun behaviour is unchanged.

Test Plan:
- Reset, then 128 in_valid samples 0..127 with src_ready=1 -> src_valid rises 2 cycles after the last write. 128 contiguous beats, real 0..127, imag 0, fft_pts=128, SOP on beat 0 only, EOP on beat 127 only, src_error=0.
- Same stimulus with src_ready toggled 1,0,0,1 repeating -> every beat is transferred exactly once in order, and src_data/SOP/EOP are stable across all stalled cycles.
- 384 continuous samples with src_ready=0 -> banks 0 and 1 fill and samples 256..383 drop. overrun=1 (ovr_count=128 if enabled). Releasing ready yields packets 0..127 then 128..255, separated by 1 bubble.
- inverse=1 during frame A and 0 during frame B -> packet A has all beats with inverse bit 1; packet B has 0.
- Assert reset_reset at beat 50 of a packet -> next cycle src_valid=0 and overrun=0. New 128 samples produce a clean packet beginning with SOP.
- overrun set, then clr_overrun pulsed while a drop occurs -> overrun stays 1. Pulse clr_overrun alone -> overrun=0 next cycle.

Source files
------------

// File: rtl/fft_frame_packetizer_if.sv
// Avalon-ST source bundle between the frame packetizer and the FFT core sink.
// src_data layout is {inverse, fft_pts, imag, real}.
interface fft_frame_packetizer_if #(
  parameter int DW    = 10,
  parameter int PTS_W = 8
) ();
  localparam int DATA_W = 1 + PTS_W + 2 * DW;

  logic              src_valid;
  logic              src_ready;
  logic [1:0]        src_error;
  logic              src_sop;
  logic              src_eop;
  logic [DATA_W-1:0] src_data;

  modport master (
    output src_valid, src_error, src_sop, src_eop, src_data,
    input  src_ready
  );

  modport slave (
    input  src_valid, src_error, src_sop, src_eop, src_data,
    output src_ready
  );
endinterface

// File: rtl/fft_frame_packetizer.sv
// Ping-pong framer: packs a free-running real sample stream into FFT_LEN-point
// Avalon-ST packets for the FFT sink. Define FFT_PKT_OVR_CNT_EN to add ovr_count.
module fft_frame_packetizer #(
  parameter int DW      = 10,
  parameter int FFT_LEN = 128,
  parameter int PTS_W   = 8
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          inverse,
  output logic          overrun,
  input  logic          clr_overrun,
`ifdef FFT_PKT_OVR_CNT_EN
  output logic [15:0]   ovr_count,
`endif
  fft_frame_packetizer_if.master src
);
  localparam int             AW       = $clog2(FFT_LEN);
  localparam int             DATA_W   = 1 + PTS_W + 2 * DW;
  localparam logic [AW-1:0]  LAST_IDX = AW'(FFT_LEN - 1);
  localparam logic [PTS_W-1:0] PTS_VAL = PTS_W'(FFT_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFETCH,
    S_SEND
  } rd_state_e;

  // Both banks share one RAM; the bank select is the address MSB.
  logic [DW-1:0] mem [2*FFT_LEN];

  logic [1:0]    bank_full;
  logic [1:0]    bank_inv;

  // Write side
  logic          wr_bank;
  logic [AW-1:0] wr_idx;
  logic          inv_cur;
  logic          wr_en;
  logic          wr_last;
  logic          drop;

  // Read side
  rd_state_e     state_q;
  rd_state_e     state_d;
  logic          rd_bank;
  logic [AW-1:0] beat_idx;
  logic [AW-1:0] rd_idx;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          send;
  logic          xfer;
  logic          last_beat;
  logic          eop_xfer;

  // A full target bank means the reader has not drained it yet; the sample is lost.
  assign wr_en   = in_valid && !bank_full[wr_bank];
  assign drop    = in_valid &&  bank_full[wr_bank];
  assign wr_last = wr_en && (wr_idx == LAST_IDX);

  assign send      = (state_q == S_SEND);
  assign xfer      = send && src.src_ready;
  assign last_beat = (beat_idx == LAST_IDX);
  assign eop_xfer  = xfer && last_beat;

  // NOTE: the sample RAM has no reset; bank_full alone decides what is valid,
  // so clearing storage would only cost a reset fan-out with no benefit.
  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_idx}] <= in_data;
    end
    if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_idx}];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every register regardless of order.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_idx  = '0;
    unique case (state_q)
      S_IDLE: begin
        // Banks fill and drain in the same alternating order, so the next
        // frame to send is always in rd_bank.
        if (bank_full[rd_bank]) begin
          state_d = S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        rd_en   = 1'b1;
        rd_idx  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          if (last_beat) begin
            state_d = bank_full[~rd_bank] ? S_PREFETCH : S_IDLE;
          end else begin
            rd_en  = 1'b1;
            rd_idx = beat_idx + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bank_full <= '0;
      bank_inv  <= '0;
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      inv_cur   <= 1'b0;
      rd_bank   <= 1'b0;
      beat_idx  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_idx == '0) begin
          inv_cur <= inverse;
        end
        if (wr_last) begin
          bank_full[wr_bank] <= 1'b1;
          bank_inv[wr_bank]  <= inv_cur;
          wr_bank            <= ~wr_bank;
          wr_idx             <= '0;
        end else begin
          wr_idx <= wr_idx + AW'(1);
        end
      end

      // The written bank is never the one being read, so these bits never collide.
      if (eop_xfer) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end

      if (rd_en) begin
        beat_idx <= rd_idx;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef FFT_PKT_OVR_CNT_EN
  // A drop in the same cycle as the clear counts as the first drop after it.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ovr_count <= '0;
    end else if (drop) begin
      if (clr_overrun) begin
        ovr_count <= 16'd1;
      end else if (ovr_count != 16'hFFFF) begin
        ovr_count <= ovr_count + 16'd1;
      end
    end else if (clr_overrun) begin
      ovr_count <= '0;
    end
  end
`endif

  // Payload is gated by valid so the bus reads zero whenever nothing is offered.
  assign src.src_valid = send;
  assign src.src_sop   = send && (beat_idx == '0);
  assign src.src_eop   = send && last_beat;
  assign src.src_error = 2'b00;
  assign src.src_data  = send ? {bank_inv[rd_bank], PTS_VAL, {DW{1'b0}}, rd_data}
                              : {DATA_W{1'b0}};
endmodule

// File: tb/tb_fft_frame_packetizer.sv
// Self-checking bench for fft_frame_packetizer: frame-level reference model
// (sample queues, pending-frame count) compared beat by beat against the DUT.
module tb_fft_frame_packetizer;
  localparam int DW      = 10;
  localparam int FFT_LEN = 128;
  localparam int PTS_W   = 8;
  localparam int DATA_W  = 1 + PTS_W + 2 * DW;
  localparam logic [PTS_W-1:0] PTS_VAL = PTS_W'(FFT_LEN);

  logic          clk = 1'b0;
  logic          reset_reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          inverse = 1'b0;
  logic          clr_overrun = 1'b0;
  logic          overrun;
`ifdef FFT_PKT_OVR_CNT_EN
  logic [15:0]   ovr_count;
`endif

  fft_frame_packetizer_if #(.DW(DW), .PTS_W(PTS_W)) src ();

  fft_frame_packetizer #(.DW(DW), .FFT_LEN(FFT_LEN), .PTS_W(PTS_W)) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .inverse     (inverse),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
`ifdef FFT_PKT_OVR_CNT_EN
    .ovr_count   (ovr_count),
`endif
    .src         (src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  // Reference model: completed frames waiting to be sent, plus the frame being filled.
  beat_t         exp_q[$];
  logic [DW-1:0] part[$];
  logic          part_inv;
  int            full_cnt;
  logic          m_ovr;
  int            m_cnt;

  int   checks, errors;
  int   edge_n, last_eop_edge, sop_gap, beat_cnt, inv_ones;
  logic in_pkt, prev_stall, prev_sop, prev_eop;
  logic [DATA_W-1:0] prev_data;

  task automatic model_reset();
    exp_q.delete();
    part.delete();
    full_cnt   = 0;
    m_ovr      = 1'b0;
    m_cnt      = 0;
    in_pkt     = 1'b0;
    prev_stall = 1'b0;
  endtask

  // One clock: called just after a falling edge with inputs already set; models
  // the coming rising edge, then waits for the next falling edge and checks overrun.
  task automatic step();
    beat_t b;
    logic  eop_x;
    eop_x = 1'b0;
    edge_n++;
    if (reset_reset) begin
      model_reset();
    end else begin
      if (prev_stall) begin
        checks++;
        if (src.src_valid !== 1'b1 || src.src_data !== prev_data ||
            src.src_sop !== prev_sop || src.src_eop !== prev_eop) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h s=%b e=%b expected v=1 d=%h s=%b e=%b",
                   src.src_valid, src.src_data, src.src_sop, src.src_eop,
                   prev_data, prev_sop, prev_eop);
        end
      end
      if (in_pkt) begin
        checks++;
        if (src.src_valid !== 1'b1) begin
          errors++;
          $display("FAIL valid_midpkt: got %b expected 1 at edge %0d", src.src_valid, edge_n);
        end
      end
      checks++;
      if (src.src_error !== 2'b00) begin
        errors++;
        $display("FAIL src_error: got %b expected 00", src.src_error);
      end
      if (src.src_valid === 1'b1 && src.src_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h expected no beat", src.src_data);
        end else begin
          b = exp_q.pop_front();
          if (src.src_data !== b.data || src.src_sop !== b.sop || src.src_eop !== b.eop) begin
            errors++;
            $display("FAIL beat: got d=%h s=%b e=%b expected d=%h s=%b e=%b",
                     src.src_data, src.src_sop, src.src_eop, b.data, b.sop, b.eop);
          end
          beat_cnt++;
          if (src.src_data[DATA_W-1] === 1'b1) inv_ones++;
          if (b.sop) begin
            sop_gap = edge_n - last_eop_edge;
            in_pkt  = 1'b1;
          end
          if (b.eop) begin
            eop_x         = 1'b1;
            last_eop_edge = edge_n;
            in_pkt        = 1'b0;
          end
        end
      end
      prev_stall = (src.src_valid === 1'b1) && (src.src_ready !== 1'b1);
      prev_data  = src.src_data;
      prev_sop   = src.src_sop;
      prev_eop   = src.src_eop;

      // Write side: a sample is lost only when both banks hold undrained frames.
      if (in_valid) begin
        if (part.size() == 0 && full_cnt == 2) begin
          m_ovr = 1'b1;
          if (clr_overrun)        m_cnt = 1;
          else if (m_cnt < 65535) m_cnt++;
        end else begin
          if (part.size() == 0) part_inv = inverse;
          part.push_back(in_data);
          if (part.size() == FFT_LEN) begin
            for (int k = 0; k < FFT_LEN; k++) begin
              b.data = {part_inv, PTS_VAL, {DW{1'b0}}, part[k]};
              b.sop  = (k == 0);
              b.eop  = (k == FFT_LEN - 1);
              exp_q.push_back(b);
            end
            part.delete();
            full_cnt++;
          end
          if (clr_overrun) begin
            m_ovr = 1'b0;
            m_cnt = 0;
          end
        end
      end else if (clr_overrun) begin
        m_ovr = 1'b0;
        m_cnt = 0;
      end
      if (eop_x) full_cnt--;
    end
    @(negedge clk);
    checks++;
    if (overrun !== m_ovr) begin
      errors++;
      $display("FAIL overrun: got %b expected %b at edge %0d", overrun, m_ovr, edge_n);
    end
`ifdef FFT_PKT_OVR_CNT_EN
    checks++;
    if (ovr_count !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL ovr_count: got %0d expected %0d", ovr_count, m_cnt);
    end
`endif
  endtask

  task automatic do_reset();
    reset_reset     = 1'b1;
    in_valid        = 1'b0;
    clr_overrun     = 1'b0;
    src.src_ready   = 1'b0;
    step();
    reset_reset     = 1'b0;
  endtask

  task automatic drive_samples(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = rnd ? DW'($urandom) : DW'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    src.src_ready = 1'b1;
    while (exp_q.size() > 0 && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats left expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    src.src_ready = 1'b1;
    in_valid      = 1'b1;
    do_reset();
    checks++;
    if (src.src_valid !== 1'b0 || src.src_sop !== 1'b0 || src.src_eop !== 1'b0 ||
        src.src_data !== '0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b s=%b e=%b d=%h ovr=%b expected all 0",
               src.src_valid, src.src_sop, src.src_eop, src.src_data, overrun);
    end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    src.src_ready = 1'b1;
    inverse       = 1'b0;
    drive_samples(FFT_LEN, 0, 1'b0);
    n = 0;
    while (src.src_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected 2", n);
    end
    beat_cnt = 0;
    repeat (FFT_LEN) step();
    checks++;
    if (beat_cnt != FFT_LEN || exp_q.size() != 0 || src.src_valid !== 1'b0) begin
      errors++;
      $display("FAIL contiguous: got beats=%0d left=%0d valid=%b expected %0d 0 0",
               beat_cnt, exp_q.size(), src.src_valid, FFT_LEN);
    end
  endtask

  task automatic test_stall();
    int n;
    logic [3:0] pat;
    pat = 4'b1001;
    do_reset();
    n = 0;
    while ((n < FFT_LEN || exp_q.size() > 0) && n < 2000) begin
      src.src_ready = pat[n % 4];
      in_valid      = (n < FFT_LEN);
      in_data       = DW'(n);
      step();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: got %0d beats left expected 0", exp_q.size());
    end
  endtask

  task automatic test_overrun();
    do_reset();
    drive_samples(3 * FFT_LEN, 0, 1'b0);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
`ifdef FFT_PKT_OVR_CNT_EN
    checks++;
    if (ovr_count !== 16'(FFT_LEN)) begin
      errors++;
      $display("FAIL ovr_count_384: got %0d expected %0d", ovr_count, FFT_LEN);
    end
`endif
    sop_gap = 0;
    drain("overrun");
    checks++;
    if (sop_gap != 2) begin
      errors++;
      $display("FAIL bubble: got %0d edges EOP->SOP expected 2", sop_gap);
    end
  endtask

  task automatic test_inverse();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FFT_LEN; i++) begin
        inverse  = (i == 0) ? (f == 0) : 1'($urandom);
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        step();
      end
    end
    in_valid = 1'b0;
    inv_ones = 0;
    drain("inverse");
    checks++;
    if (inv_ones != FFT_LEN) begin
      errors++;
      $display("FAIL inverse_bits: got %0d ones expected %0d", inv_ones, FFT_LEN);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    drive_samples(3 * FFT_LEN, 0, 1'b1);
    src.src_ready = 1'b1;
    beat_cnt      = 0;
    n             = 0;
    while (beat_cnt < 50 && n < 500) begin
      step();
      n++;
    end
    reset_reset = 1'b1;
    step();
    reset_reset = 1'b0;
    checks++;
    if (src.src_valid !== 1'b0 || overrun !== 1'b0 || beat_cnt != 50) begin
      errors++;
      $display("FAIL reset_mid: got v=%b ovr=%b beats=%0d expected 0 0 50",
               src.src_valid, overrun, beat_cnt);
    end
    drive_samples(FFT_LEN, 0, 1'b1);
    drain("reset_mid");
  endtask

  task automatic test_clr_overrun();
    do_reset();
    drive_samples(2 * FFT_LEN + 1, 0, 1'b1);
    in_valid    = 1'b1;
    clr_overrun = 1'b1;
    step();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_drop: got %b expected 1", overrun);
    end
    in_valid = 1'b0;
    step();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: got %b expected 0", overrun);
    end
    drain("clr");
  endtask

  task automatic test_random();
    int rdy_w;
    do_reset();
    rdy_w = 2;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) rdy_w = 1 + int'($urandom_range(0, 3));
      src.src_ready = ($urandom_range(0, 3) < rdy_w);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_data       = DW'($urandom);
      inverse       = 1'($urandom);
      clr_overrun   = ($urandom_range(0, 63) == 0);
      step();
    end
    in_valid    = 1'b0;
    clr_overrun = 1'b0;
    drain("random");
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    edge_n        = 0;
    last_eop_edge = 0;
    sop_gap       = 0;
    beat_cnt      = 0;
    inv_ones      = 0;
    part_inv      = 1'b0;
    prev_data     = '0;
    prev_sop      = 1'b0;
    prev_eop      = 1'b0;
    src.src_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_inverse();
    test_reset_mid();
    test_clr_overrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
